// File: rtl/rld_pkg.sv
// Shared types and constants for the run-length detector.
// Holds the per-channel state encoding and the code-width helper.
package rld_pkg;

    // State encoding constants
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ZERO = 2'd1;
    localparam logic [1:0] ST_ONES = 2'd2;
    localparam logic [1:0] ST_LONG = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        ZERO = ST_ZERO,
        ONES = ST_ONES,
        LONG = ST_LONG
    } rld_state_e;

    // Bits needed to hold run lengths 0..max_run
    function automatic int rld_code_w(input int max_run);
        return $clog2(max_run + 1);
    endfunction

endpackage

// File: rtl/rld_channel.sv
// One channel of the run-length detector: FSM, run counter, output
// registers and (with RLD_HIT_COUNT_EN) a saturating hit counter.
// Ports: clk_i, rst_i (sync, active-high), x_i serial input,
//        y_o last run length, y_valid_o / ovf_o one-cycle pulses,
//        hits_o detection count (RLD_HIT_COUNT_EN only).
module rld_channel
    import rld_pkg::*;
#(
    parameter int MAX_RUN = 3,
    parameter int CODE_W  = 2
`ifdef RLD_HIT_COUNT_EN
    ,
    parameter int HIT_W   = 8
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              x_i,
    output logic [CODE_W-1:0] y_o,
    output logic              y_valid_o,
    output logic              ovf_o
`ifdef RLD_HIT_COUNT_EN
    ,
    output logic [HIT_W-1:0]  hits_o
`endif
);

    localparam logic [CODE_W-1:0] MAX_CNT = CODE_W'(MAX_RUN);
    localparam logic [CODE_W-1:0] ONE_CNT = CODE_W'(1);

    rld_state_e        state_q, state_d;
    logic [CODE_W-1:0] cnt_q, cnt_d;
    logic [CODE_W-1:0] y_q, y_d;
    logic              yv_q, yv_d;
    logic              ovf_q, ovf_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            y_q     <= '0;
            yv_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            yv_q    <= yv_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        yv_d    = 1'b0;
        ovf_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!x_i) state_d = ZERO;
            end
            ZERO: begin
                if (x_i) begin
                    state_d = ONES;
                    cnt_d   = ONE_CNT;
                end
            end
            ONES: begin
                if (x_i) begin
                    // Counter stops at MAX_RUN; the LONG state remembers
                    // the excess so cnt never wraps.
                    if (cnt_q == MAX_CNT) state_d = LONG;
                    else                  cnt_d   = cnt_q + ONE_CNT;
                end else begin
                    y_d     = cnt_q;
                    yv_d    = 1'b1;
                    state_d = ZERO;
                end
            end
            LONG: begin
                if (!x_i) begin
                    ovf_d   = 1'b1;
                    state_d = ZERO;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign y_o       = y_q;
    assign y_valid_o = yv_q;
    assign ovf_o     = ovf_q;

`ifdef RLD_HIT_COUNT_EN
    logic [HIT_W-1:0] hits_q, hits_d;

    // Counts on the same edge that raises y_valid; sticks at all-ones.
    always_comb begin
        hits_d = hits_q;
        if (yv_d && (hits_q != '1)) hits_d = hits_q + HIT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) hits_q <= '0;
        else       hits_q <= hits_d;
    end

    assign hits_o = hits_q;
`endif

endmodule

// File: rtl/run_length_detector.sv
// Multi-channel detector for the serial pattern 0,1^k,0 (1<=k<=MAX_RUN).
// Ports: clk, rst (sync, active-high), x[CHANNELS] serial inputs,
//        y packed per-channel codes (CODE_W each), y_valid, ovf pulses,
//        hits per-channel counts (HIT_W each) when RLD_HIT_COUNT_EN is defined.
module run_length_detector
    import rld_pkg::*;
#(
    parameter int  CHANNELS = 1,
    parameter int  MAX_RUN  = 3
`ifdef RLD_HIT_COUNT_EN
    ,
    parameter int  HIT_W    = 8
`endif
    ,
    localparam int CODE_W   = rld_code_w(MAX_RUN)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CHANNELS-1:0]        x,
    output logic [CHANNELS*CODE_W-1:0] y,
    output logic [CHANNELS-1:0]        y_valid,
    output logic [CHANNELS-1:0]        ovf
`ifdef RLD_HIT_COUNT_EN
    ,
    output logic [CHANNELS*HIT_W-1:0]  hits
`endif
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        rld_channel #(
            .MAX_RUN (MAX_RUN),
            .CODE_W  (CODE_W)
`ifdef RLD_HIT_COUNT_EN
            ,
            .HIT_W   (HIT_W)
`endif
        ) u_ch (
            .clk_i     (clk),
            .rst_i     (rst),
            .x_i       (x[i]),
            .y_o       (y[i*CODE_W +: CODE_W]),
            .y_valid_o (y_valid[i]),
            .ovf_o     (ovf[i])
`ifdef RLD_HIT_COUNT_EN
            ,
            .hits_o    (hits[i*HIT_W +: HIT_W])
`endif
        );
    end

endmodule

// File: tb/tb_run_length_detector.sv
// Scoreboard bench for run_length_detector (4 channels, MAX_RUN=6).
// Directed pattern sequences followed by randomized traffic.
module tb_run_length_detector;

    localparam int CH = 4;
    localparam int MR = 6;
    localparam int CW = $clog2(MR + 1);
    localparam int HW = 2;

    typedef struct packed {
        logic [CH*CW-1:0] y;
        logic [CH-1:0]    yv;
        logic [CH-1:0]    ovf;
        logic [CH*HW-1:0] hits;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [CH-1:0]    x;
    logic [CH*CW-1:0] y;
    logic [CH-1:0]    y_valid;
    logic [CH-1:0]    ovf;
`ifdef RLD_HIT_COUNT_EN
    logic [CH*HW-1:0] hits;
`endif

    run_length_detector #(
        .CHANNELS (CH),
        .MAX_RUN  (MR)
`ifdef RLD_HIT_COUNT_EN
        ,
        .HIT_W    (HW)
`endif
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .x       (x),
        .y       (y),
        .y_valid (y_valid),
        .ovf     (ovf)
`ifdef RLD_HIT_COUNT_EN
        ,
        .hits    (hits)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    exp_t sbq[$];

    // Reference model: pattern-level bookkeeping per channel.
    int run_len [CH];
    bit seen0   [CH];
    int last_y  [CH];
    int hitcnt  [CH];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, req, $time);
        end
    endtask

    task automatic step(input logic [CH-1:0] xv, input logic r);
        exp_t e;
        @(negedge clk);
        x   = xv;
        rst = r;
        e   = '0;
        for (int c = 0; c < CH; c++) begin
            if (r) begin
                run_len[c] = 0;
                seen0[c]   = 0;
                last_y[c]  = 0;
                hitcnt[c]  = 0;
            end else if (xv[c]) begin
                if (seen0[c]) run_len[c]++;
            end else begin
                if (run_len[c] > 0) begin
                    if (run_len[c] <= MR) begin
                        last_y[c] = run_len[c];
                        e.yv[c]   = 1'b1;
                        if (hitcnt[c] < (1 << HW) - 1) hitcnt[c]++;
                    end else begin
                        e.ovf[c] = 1'b1;
                    end
                end
                run_len[c] = 0;
                seen0[c]   = 1;
            end
            e.y[c*CW +: CW]    = CW'(last_y[c]);
            e.hits[c*HW +: HW] = HW'(hitcnt[c]);
        end
        sbq.push_back(e);
    endtask

    // Same bit sequence on every channel
    task automatic seq_all(input string s);
        for (int i = 0; i < s.len(); i++)
            step({CH{s[i] == "1"}}, 1'b0);
    endtask

    // Monitor: compares the response to each sampled edge.
    exp_t me;
    always @(posedge clk) begin
        #2;
        if (sbq.size() > 0) begin
            me = sbq.pop_front();
            chk("y", 64'(y), 64'(me.y));
            chk("y_valid", 64'(y_valid), 64'(me.yv));
            chk("ovf", 64'(ovf), 64'(me.ovf));
            chk("no_both", 64'(y_valid & ovf), 64'd0);
`ifdef RLD_HIT_COUNT_EN
            chk("hits", 64'(hits), 64'(me.hits));
`endif
        end
    end

    int lens [CH];
    logic [CH-1:0] xv;

    initial begin
        x   = '0;
        rst = 1'b1;
        step('0, 1'b1);
        step('0, 1'b1);

        // Runs of 1,4,6,7 ending together
        lens = '{1, 4, 6, 7};
        for (int t = 0; t <= 8; t++) begin
            for (int c = 0; c < CH; c++)
                xv[c] = (t >= 8 - lens[c]) && (t < 8);
            step(xv, 1'b0);
        end
        step('0, 1'b0);

        // Lengths 1,2,3, an overflow run, then overlap
        seq_all("010");
        seq_all("0110");
        seq_all("01110");
        seq_all("011111110");
        seq_all("01010");
        seq_all("0111111");
        seq_all("0");

        // Reset mid-run, then ones without a leading zero
        seq_all("011");
        step('1, 1'b1);
        step('1, 1'b1);
        seq_all("000");
        step('0, 1'b1);
        seq_all("1110");
        seq_all("00");

        // Hit saturation with an overflow run in between
        seq_all("0101");
        seq_all("01111111");
        seq_all("010101010");

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < CH; c++)
                xv[c] = ($urandom_range(0, 99) < 70);
            step(xv, $urandom_range(0, 299) == 0);
        end
        step('0, 1'b0);

        repeat (4) @(negedge clk);
        chk("drain", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/run_length_detector.md
Name: run_length_detector

Overview:
- Multi-channel, parametrised detector for the serial pattern 0, 1^k, 0 with 1 <= k <= MAX_RUN.
- On each completed pattern it reports the run length k as a registered code; runs longer than MAX_RUN raise an overflow pulse.
- Generalises the team's fixed 2-bit run detector to any channel count and any run limit. Defaults (CHANNELS=1, MAX_RUN=3) reproduce the 2-bit single-channel behaviour.
- Sits after input synchronisers; its outputs feed status logic.

Parameters:
- CHANNELS, 1, number of independent serial inputs, each with its own FSM.
- MAX_RUN, 3, longest run of ones reported as a valid code (>= 1).
- CODE_W, $clog2(MAX_RUN+1), width of each channel's run-length code (localparam, derived).
- HIT_W, 8, width of the per-channel hit counter (used only with RLD_HIT_COUNT_EN).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- x  in  CHANNELS  serial data, bit i = channel i, sampled each rising edge.
- y  out  CHANNELS*CODE_W  per-channel last detected run length; channel i occupies [i*CODE_W +: CODE_W].
- y_valid  out  CHANNELS  one-cycle pulse per channel when y for that channel updates.
- ovf  out  CHANNELS  one-cycle pulse when a run longer than MAX_RUN terminates.
- hits  out  CHANNELS*HIT_W  per-channel saturating detection count (present only with RLD_HIT_COUNT_EN).

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: every FSM goes to IDLE and the run counter clears. y, y_valid, ovf and hits all reset to 0. A run in progress when rst rises is discarded. rst has priority over every other event.
- Channels are fully independent; no cross-channel interaction.
- Per-channel FSM (values are those sampled at each edge):
  - IDLE: x=0 -> ZERO; x=1 -> stay. A leading 0 is required after reset.
  - ZERO: x=1 -> ONES with cnt=1; x=0 -> stay.
  - ONES, x=1: if cnt==MAX_RUN -> LONG; otherwise cnt++.
  - ONES, x=0: y<=cnt, y_valid<=1, -> ZERO.
  - LONG, x=1: stay.
  - LONG, x=0: ovf<=1, -> ZERO; y is unchanged.
- Overlap: the terminating 0 also serves as the leading 0 of the next pattern. For example 0,1,0,1,0 yields two detections of k=1.
- Latency: y/y_valid (or ovf) are asserted in the cycle after the edge that samples the terminating 0, i.e. registered, 1 cycle.
- y is sticky: it holds the last code until the next detection or reset. Code 0 means "nothing detected since reset".
- y_valid and ovf are single-cycle pulses. They can never both be high on the same channel in the same cycle.
- cnt width is CODE_W. It never exceeds MAX_RUN, so no wrap-around is possible.

Optional Feature:
- RLD_HIT_COUNT_EN defined: adds the hits port and a per-channel HIT_W-bit counter.
  - The counter increments in the same cycle y_valid asserts and saturates at all-ones.
  - ovf events are not counted.
  - Reset clears it to 0.
- Undefined: no hits port and no counter logic. All other behaviour is identical.

Decomposition:
- Shared package rld_pkg holds:
  - the state enum (IDLE, ZERO, ONES, LONG) as a 2-bit typedef;
  - the encoding constants;
  - a function computing CODE_W from MAX_RUN.
- Sub-module rld_channel contains one channel's FSM, counter, output registers and optional hit counter.
- Top instantiates CHANNELS copies of rld_channel via generate and packs their outputs.

Test Plan:
- Defaults, after reset: drive 0,1,0. -> y=1 with y_valid pulse 1 cycle after the 0 is sampled. Then drive 0,1,1,0 -> y=2. Then drive 0,1,1,1,0 -> y=3.
- Defaults: drive 0,1,1,1,1,0. -> ovf pulses for 1 cycle, y_valid stays 0, y retains its previous value.
- Overlap: drive 0,1,0,1,0. -> two y_valid pulses, each with y=1, two cycles apart.
- Reset mid-run:
  - drive 0,1,1, then assert rst for 2 cycles while x=1, then release with x=0 -> no y_valid; y=0 throughout.
  - Then drive x=1 from IDLE without a leading 0, then x=0 -> no detection.
- CHANNELS=4, MAX_RUN=6 (CODE_W=3), channels driven with run lengths 1, 4, 6 and 7 simultaneously:
  - y fields read 1, 4, 6 and unchanged(0) respectively;
  - ovf is high on channel 3 only;
  - all pulses land in the same cycle when the runs end together.
- RLD_HIT_COUNT_EN with HIT_W=2: five valid detections -> hits=1, 2, 3, 3, 3 (saturates). An intervening overflow run leaves hits unchanged.
